// File: rtl/ram_access_unit.sv
// Single-port data RAM sequencer: turns load/store/copy/fill commands from the core
// into RAM cycles and returns one completion pulse per command.
module ram_access_unit #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [ADDR_W-1:0] req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, CP_RD, CP_WR, FILL, DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  src_reg, src_next;
    logic [ADDR_W-1:0]  dst_reg, dst_next;
    logic [CNT_W-1:0]   len_reg, len_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]  mem_wdata_reg, mem_wdata_next;
    logic [DATA_W-1:0]  rsp_data_reg, rsp_data_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            len_reg       <= '0;
            cnt_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            src_reg       <= src_next;
            dst_reg       <= dst_next;
            len_reg       <= len_next;
            cnt_reg       <= cnt_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rsp_data_reg  <= rsp_data_next;
        end
    end

    // mem_wdata_reg doubles as the copy buffer: CP_RD loads it, CP_WR drives it out.
    always_comb begin
        state_next     = state_reg;
        src_next       = src_reg;
        dst_next       = dst_reg;
        len_next       = len_reg;
        cnt_next       = cnt_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rsp_data_next  = rsp_data_reg;
        cnt_inc        = cnt_reg + CNT_W'(1);

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    src_next = req_addr;
                    dst_next = req_addr2;
                    len_next = {1'b0, req_len};
                    cnt_next = '0;
                    case (req_op)
                        OP_LOAD: begin
                            state_next    = LOAD;
                            mem_addr_next = req_addr;
                        end
                        OP_STORE: begin
                            state_next     = STORE;
                            mem_addr_next  = req_addr;
                            mem_wdata_next = req_wdata;
                            rsp_data_next  = req_wdata;
                        end
                        OP_COPY: begin
                            if (req_len == '0) begin
                                state_next    = DONE;
                                rsp_data_next = '0;
                            end else begin
                                state_next    = CP_RD;
                                mem_addr_next = req_addr;
                            end
                        end
                        default: begin
                            if (req_len == '0) begin
                                state_next    = DONE;
                                rsp_data_next = '0;
                            end else begin
                                state_next     = FILL;
                                mem_addr_next  = req_addr;
                                mem_wdata_next = req_wdata;
                            end
                        end
                    endcase
                end
            end
            LOAD: begin
                rsp_data_next = mem_rdata;
                state_next    = DONE;
            end
            STORE: state_next = DONE;
            FILL: begin
                if (cnt_inc == len_reg) begin
                    state_next    = DONE;
                    rsp_data_next = DATA_W'(len_reg);
                end else begin
                    cnt_next      = cnt_inc;
                    mem_addr_next = mem_addr_reg + ADDR_W'(1);
                end
            end
            CP_RD: begin
                mem_wdata_next = mem_rdata;
                mem_addr_next  = dst_reg + cnt_reg[ADDR_W-1:0];
                state_next     = CP_WR;
            end
            CP_WR: begin
                if (cnt_inc == len_reg) begin
                    state_next    = DONE;
                    rsp_data_next = DATA_W'(len_reg);
                end else begin
                    cnt_next      = cnt_inc;
                    mem_addr_next = src_reg + cnt_inc[ADDR_W-1:0];
                    state_next    = CP_RD;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == DONE);
    assign rsp_data  = rsp_data_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_write = (state_reg == STORE) || (state_reg == FILL) || (state_reg == CP_WR);
endmodule

// File: tb/tb_ram_access_unit.sv
// Bench for ram_access_unit: a behavioural RAM plus an array-level reference model
// checks response data, latency, write counts, handshake and final RAM contents.
module tb_ram_access_unit;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr, req_addr2, req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] ram     [256];
    logic [DATA_W-1:0] ref_ram [256];

    int n_cmp = 0;
    int n_bad = 0;

    ram_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_addr2(req_addr2), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write === 1'b1) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ram_check(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_ram[i]) bad++;
        check(tag, bad, 0);
    endtask

    // Reference: apply the command to ref_ram element by element in ascending order.
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] a2,
                             input logic [7:0] n, input logic [13:0] wd,
                             output logic [13:0] e_data, output int e_lat, output int e_wr);
        case (op)
            2'b00: begin e_data = ref_ram[a]; e_lat = 2; e_wr = 0; end
            2'b01: begin ref_ram[a] = wd; e_data = wd; e_lat = 2; e_wr = 1; end
            2'b10: begin
                for (int i = 0; i < n; i++) ref_ram[8'(a2 + i)] = ref_ram[8'(a + i)];
                e_data = 14'(n); e_lat = (n == 0) ? 1 : 2 * n + 1; e_wr = n;
            end
            default: begin
                for (int i = 0; i < n; i++) ref_ram[8'(a + i)] = wd;
                e_data = 14'(n); e_lat = n + 1; e_wr = n;
            end
        endcase
    endtask

    // Called at a negedge; returns at the negedge of the cycle after rsp_valid.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] a2, input logic [7:0] n, input logic [13:0] wd,
                           output int lat, output int wr);
        int guard = 0;
        int e_lat, e_wr;
        logic [13:0] e_data, got_data;
        bit got = 0, busy_ok = 1;
        while (req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) check({tag, "_ready_wait"}, 0, 1);
        req_op = op; req_addr = a; req_addr2 = a2; req_len = n; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_op = 2'($urandom); req_addr = 8'($urandom); req_len = 8'($urandom);
        model_cmd(op, a, a2, n, wd, e_data, e_lat, e_wr);
        lat = 0; wr = 0; got_data = '0;
        for (int k = 1; k <= 600 && !got; k++) begin
            @(negedge clk);
            if (mem_write === 1'b1) wr++;
            if (req_ready !== 1'b0) busy_ok = 0;
            if (rsp_valid === 1'b1) begin got = 1; lat = k; got_data = rsp_data; end
        end
        check({tag, "_rsp_seen"}, 32'(got), 1);
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_rsp_data"}, 32'(got_data), 32'(e_data));
        check({tag, "_writes"}, wr, e_wr);
        check({tag, "_busy_not_ready"}, 32'(busy_ok), 1);
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(req_ready), 1);
        check({tag, "_rsp_one_pulse"}, 32'(rsp_valid), 0);
        ram_check({tag, "_ram"});
    endtask

    initial begin
        int lat, wr, cnt_rsp, cnt_wr;
        logic [1:0] op;
        logic [7:0] a, a2, n;
        logic [13:0] wd;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_addr2 = '0;
        req_len = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 1);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_data", 32'(rsp_data), 0);
        check("reset_mem_write", 32'(mem_write), 0);
        check("reset_mem_addr", 32'(mem_addr), 0);
        check("reset_mem_wdata", 32'(mem_wdata), 0);
        reset = 1'b0;
        @(negedge clk);

        // Give the whole RAM defined random contents through the DUT.
        for (int i = 0; i < 256; i++)
            run_cmd("preload", 2'b01, 8'(i), 8'h00, 8'h00, 14'($urandom), lat, wr);

        // Store then load.
        run_cmd("t1_store", 2'b01, 8'd3, 8'd0, 8'd0, 14'd100, lat, wr);
        run_cmd("t1_load", 2'b00, 8'd3, 8'd0, 8'd0, 14'd0, lat, wr);
        check("t1_load_val", 32'(ram[3]), 100);

        // Fill wrapping past the top of the address space.
        run_cmd("t2_fill", 2'b11, 8'd254, 8'd0, 8'd4, 14'd7, lat, wr);
        check("t2_fill_lat", lat, 5);
        check("t2_ram255", 32'(ram[255]), 7);
        check("t2_ram1", 32'(ram[1]), 7);

        // Plain copy.
        run_cmd("t3_pre0", 2'b01, 8'd0, 8'd0, 8'd0, 14'd5, lat, wr);
        run_cmd("t3_pre1", 2'b01, 8'd1, 8'd0, 8'd0, 14'd6, lat, wr);
        run_cmd("t3_pre2", 2'b01, 8'd2, 8'd0, 8'd0, 14'd9, lat, wr);
        run_cmd("t3_copy", 2'b10, 8'd0, 8'd10, 8'd3, 14'd0, lat, wr);
        check("t3_copy_lat", lat, 7);
        check("t3_ram12", 32'(ram[12]), 9);

        // Overlapping copy propagates the first word.
        run_cmd("t4_pre", 2'b01, 8'd0, 8'd0, 8'd0, 14'd42, lat, wr);
        run_cmd("t4_copy", 2'b10, 8'd0, 8'd1, 8'd3, 14'd0, lat, wr);
        check("t4_ram3", 32'(ram[3]), 42);

        // Zero-length fill and copy, then a back-to-back load.
        run_cmd("t5_fill0", 2'b11, 8'd20, 8'd0, 8'd0, 14'd5, lat, wr);
        check("t5_fill0_lat", lat, 1);
        run_cmd("t5_load", 2'b00, 8'd12, 8'd0, 8'd0, 14'd0, lat, wr);
        run_cmd("t5_copy0", 2'b10, 8'd20, 8'd40, 8'd0, 14'd0, lat, wr);

        // Randomized commands.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom); a = 8'($urandom); a2 = 8'($urandom);
            n = 8'($urandom_range(0, 12)); wd = 14'($urandom);
            run_cmd("rand", op, a, a2, n, wd, lat, wr);
        end

        // Reset during COPY len=8 while reading element 3.
        req_op = 2'b10; req_addr = 8'h40; req_addr2 = 8'h80; req_len = 8'd8; req_valid = 1'b1;
        check("t6_ready_before", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 3; i++) ref_ram[8'h80 + i] = ref_ram[8'h40 + i];
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_ready", 32'(req_ready), 1);
        check("t6_mem_write", 32'(mem_write), 0);
        check("t6_rsp_valid", 32'(rsp_valid), 0);
        check("t6_rsp_data", 32'(rsp_data), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt_rsp = 0; cnt_wr = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) cnt_rsp++;
            if (mem_write === 1'b1) cnt_wr++;
        end
        check("t6_no_rsp", cnt_rsp, 0);
        check("t6_no_write", cnt_wr, 0);
        check("t6_ready_idle", 32'(req_ready), 1);
        ram_check("t6_ram");

        run_cmd("t7_after_reset", 2'b00, 8'h81, 8'd0, 8'd0, 14'd0, lat, wr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
